// File: rtl/simple_vec_pkg.sv
// simple_vec_pkg: shared states and constants for the simple_vec_driver stimulus/checker
package simple_vec_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;
  localparam int          PRIME_CYC = 2;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;
endpackage

// File: rtl/simple_lfsr.sv
// simple_lfsr: right-shifting Fibonacci LFSR; load reseeds, adv steps once, q is the state
module simple_lfsr
  import simple_vec_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
  parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else if (load) q <= SEED;
    else if (adv) q <= {^(q & TAPS), q[W-1:1]};
endmodule

// File: rtl/simple_vec_driver.sv
// simple_vec_driver: LFSR stimulus for the `simple` netlist with a cycle-accurate golden compare
// Ports: tau2015_clk/tau2015_rst_n clock and async low reset; start/num_vec run request;
// drv_inp1/drv_inp2 registered drives; dut_out netlist output; busy/done/pass/err_cnt/first_err_idx status.
module simple_vec_driver
  import simple_vec_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
  parameter int                CNT_W  = 16
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic             drv_inp1,
  output logic             drv_inp2,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);
  state_e             st, nxt;
  logic [CNT_W-1:0]   n_q, cnt, err_nxt;
  logic [LFSR_W-1:0]  lfsr;
  logic               mq, accept, run_nxt, mis;
  assign accept  = st == IDLE && start;
  assign run_nxt = nxt == RUN;
  // the netlist's out is ~q, so a mismatch is dut_out equal to the model flop
  assign mis     = (st == RUN || st == DRAIN) && dut_out == mq;
  assign err_nxt = mis && err_cnt != '1 ? err_cnt + 1'b1 : err_cnt;
  assign busy    = st != IDLE;
  assign done    = st == DONE;
  always_comb
    nxt = st == IDLE  ? (start ? PRIME : IDLE) :
          st == PRIME ? (cnt == CNT_W'(PRIME_CYC - 1) ? (n_q == '0 ? DRAIN : RUN) : PRIME) :
          st == RUN   ? (cnt == n_q - 1'b1 ? DRAIN : RUN) :
          st == DRAIN ? DONE : IDLE;
  // the LFSR steps as its low bits are captured into the drive flops, one step per RUN cycle
  simple_lfsr #(
    .W   (LFSR_W),
    .TAPS(LFSR_W'(LFSR_TAPS)),
    .SEED(SEED)
  ) u_lfsr (
    .clk  (tau2015_clk),
    .rst_n(tau2015_rst_n),
    .load (accept),
    .adv  (run_nxt),
    .q    (lfsr)
  );
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n)
    if (!tau2015_rst_n) begin
      st            <= IDLE;
      n_q           <= '0;
      cnt           <= '0;
      mq            <= 1'b0;
      drv_inp1      <= 1'b0;
      drv_inp2      <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else begin
      st       <= nxt;
      mq       <= drv_inp1 & drv_inp2 & ~mq;
      drv_inp1 <= run_nxt & lfsr[0];
      drv_inp2 <= run_nxt & lfsr[1];
      // cnt counts PRIME cycles, then doubles as RUN length and compare index
      cnt      <= accept || (st == PRIME && nxt != PRIME) ? '0 :
                  st == PRIME || st == RUN ? cnt + 1'b1 : cnt;
      if (accept) begin
        n_q           <= num_vec;
        err_cnt       <= '0;
        first_err_idx <= '1;
        pass          <= 1'b0;
      end else begin
        err_cnt <= err_nxt;
        if (mis && err_cnt == '0) first_err_idx <= cnt;
        if (st == DRAIN) pass <= err_nxt == '0;
      end
    end
endmodule

// File: tb/tb_simple_vec_driver.sv
// tb_simple_vec_driver: directed checks of simple_vec_driver against a behavioural simple netlist
module tb_simple_vec_driver;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, inv = 1'b0, sq;
  logic [15:0] num_vec = '0, err_cnt, first_err_idx;
  logic        drv_inp1, drv_inp2, dut_out, busy, done, pass;
  int          tests = 0, fails = 0, lat;

  simple_vec_driver dut (
    .tau2015_clk  (clk),
    .tau2015_rst_n(rst_n),
    .start        (start),
    .num_vec      (num_vec),
    .drv_inp1     (drv_inp1),
    .drv_inp2     (drv_inp2),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sq <= drv_inp1 & drv_inp2 & ~sq;
  assign dut_out = inv ? sq : ~sq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [15:0] n);
    start   = 1'b1;
    num_vec = n;
    step(1);
    start   = 1'b0;
    num_vec = 16'h1234;
  endtask

  task automatic wait_done(input int lat0, output int l);
    l = lat0;
    while (!done && l < 300) begin
      step(1);
      l++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_drv"}, {drv_inp1, drv_inp2}, 2'b00);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_first"}, first_err_idx, 16'hFFFF);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(2);
    check_idle("rst");
    @(negedge clk) rst_n = 1'b1;
    step(10);
    check_idle("idle10");

    start_run(8);
    check("n8_busy", busy, 1);
    check("n8_prime_drv", {drv_inp1, drv_inp2}, 2'b00);
    step(2);
    check("n8_run0_drv", {drv_inp1, drv_inp2}, 2'b10);
    step(1);
    check("n8_run1_drv", {drv_inp1, drv_inp2}, 2'b00);
    step(3);
    check("n8_run4_drv", {drv_inp1, drv_inp2}, 2'b01);
    wait_done(7, lat);
    check("n8_lat", lat, 12);
    check("n8_busy_done", busy, 1);
    check("n8_err", err_cnt, 0);
    check("n8_pass", pass, 1);
    check("n8_first", first_err_idx, 16'hFFFF);
    step(1);
    check("n8_done_pulse", done, 0);
    check("n8_pass_hold", pass, 1);

    inv = 1'b1;
    start_run(8);
    wait_done(1, lat);
    check("inv_lat", lat, 12);
    check("inv_err", err_cnt, 9);
    check("inv_first", first_err_idx, 0);
    check("inv_pass", pass, 0);
    inv = 1'b0;
    step(2);

    start_run(8);
    step(7);
    inv = 1'b1;
    wait_done(8, lat);
    inv = 1'b0;
    check("mid_err", err_cnt, 4);
    check("mid_first", first_err_idx, 5);
    step(2);

    start_run(0);
    wait_done(1, lat);
    check("n0_lat", lat, 4);
    check("n0_err", err_cnt, 0);
    check("n0_pass", pass, 1);
    step(1);
    inv = 1'b1;
    start_run(0);
    wait_done(1, lat);
    inv = 1'b0;
    check("n0inv_err", err_cnt, 1);
    check("n0inv_first", first_err_idx, 0);
    step(2);

    inv = 1'b1;
    start_run(4);
    step(3);
    start   = 1'b1;
    num_vec = 16'd2;
    step(1);
    start   = 1'b0;
    wait_done(5, lat);
    check("ign_lat", lat, 8);
    check("ign_err", err_cnt, 5);
    step(1);
    check("ign_busy_after", busy, 0);
    check("ign_done_after", done, 0);
    inv = 1'b0;
    start_run(4);
    check("b2b_busy", busy, 1);
    check("b2b_err_clr", err_cnt, 0);
    check("b2b_pass_clr", pass, 0);
    check("b2b_first_clr", first_err_idx, 16'hFFFF);
    wait_done(1, lat);
    check("b2b_lat", lat, 8);
    check("b2b_err", err_cnt, 0);
    check("b2b_pass", pass, 1);
    step(2);

    inv = 1'b1;
    start_run(8);
    step(5);
    check("rr_err_pre", err_cnt, 3);
    check("rr_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle("rr");
    inv = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(2);
    start_run(4);
    wait_done(1, lat);
    check("rr4_lat", lat, 8);
    check("rr4_err", err_cnt, 0);
    check("rr4_pass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
